// File: rtl/branch_redirect_fetch.sv
// branch_redirect_fetch
// PC register and IF/ID pipeline register sitting behind the decode-stage
// branch comparator. A taken branch resolved in ID redirects fetch and
// replaces the wrong-path instruction in IF/ID with a single NOP bubble.
// A hazard-unit stall freezes the PC, IF/ID and the redirect FSM.
// Branch decisions that arrive while ID holds a squash bubble are ignored,
// because they were produced by that bubble.
//
// Optional build macro: BRANCH_STATS_EN adds the taken_count and
// stall_count outputs. The core behaviour is identical with or without it.

module branch_redirect_fetch #(
    parameter int                 XLEN      = 64,
    parameter int                 INSTR_W   = 32,
    parameter logic [XLEN-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000013)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_valid,
    input  logic               branch_sel,
    input  logic [XLEN-1:0]    branch_target,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [XLEN-1:0]    pc_out,
    output logic [XLEN-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic               ifid_valid,
    output logic               flush,
    output logic               misalign_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]        taken_count,
    output logic [31:0]        stall_count
`endif
);

    // RUN: ID holds a real instruction or a start-up bubble.
    // FLUSH: ID holds the bubble inserted by a taken branch.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    ifid_pc_q, ifid_pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic               flush_q, flush_d;
    logic               misalign_q, misalign_d;

    // A branch only counts when ID holds a real instruction; in FLUSH the
    // comparator is looking at the bubble.
    logic taken;
    logic redirect;
    logic target_misaligned;

    assign taken             = branch_valid & branch_sel & (state_q == ST_RUN);
    assign redirect          = taken & ~stall;
    assign target_misaligned = (branch_target[1:0] != 2'b00);

    // Next-state for PC, IF/ID and the redirect FSM; stall has priority over
    // a taken branch so the branch is simply re-presented after the stall.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        if (!stall) begin
            if (taken) begin
                // Redirect: the instruction fetched this cycle is wrong-path,
                // so IF/ID captures a bubble tagged with its PC.
                pc_d         = {branch_target[XLEN-1:2], 2'b00};
                ifid_pc_d    = pc_q;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
                state_d      = ST_FLUSH;
            end else begin
                // Sequential fetch; PC wraps silently at the top of memory.
                pc_d         = pc_q + PC_STEP;
                ifid_pc_d    = pc_q;
                ifid_instr_d = instr_in;
                ifid_valid_d = 1'b1;
                state_d      = ST_RUN;
            end
        end

        flush_d    = (state_d == ST_FLUSH);
        misalign_d = misalign_q | (redirect & target_misaligned);
    end

    // Single register bank for the FSM and all of its registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            flush_q      <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            flush_q      <= flush_d;
            misalign_q   <= misalign_d;
        end
    end

    assign pc_out       = pc_q;
    assign ifid_pc      = ifid_pc_q;
    assign ifid_instr   = ifid_instr_q;
    assign ifid_valid   = ifid_valid_q;
    assign flush        = flush_q;
    assign misalign_err = misalign_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_count_q, taken_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Event counters; both wrap naturally at 32 bits.
    always_comb begin
        taken_count_d = taken_count_q;
        stall_count_d = stall_count_q;
        if (redirect) begin
            taken_count_d = taken_count_q + 32'd1;
        end
        if (stall) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            taken_count_q <= taken_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign taken_count = taken_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_branch_redirect_fetch.sv
// Scoreboard bench for branch_redirect_fetch: directed steps push the
// hand-computed post-edge state into a queue; a monitor pops and compares.
`timescale 1ns/1ps

module tb_branch_redirect_fetch;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] I0  = 32'h00500093;
    localparam logic [31:0] I1  = 32'h00A00113;
    localparam logic [31:0] I2  = 32'h002081B3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic        branch_sel = 1'b0;
    logic [63:0] branch_target = '0;
    logic [31:0] instr_in = I0;
    logic [63:0] pc_out;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        flush;
    logic        misalign_err;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_count;
    logic [31:0] stall_count;
`endif

    branch_redirect_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_sel    (branch_sel),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .flush         (flush),
        .misalign_err  (misalign_err)
`ifdef BRANCH_STATS_EN
        ,
        .taken_count   (taken_count),
        .stall_count   (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] ifpc;
        logic [31:0] ins;
        logic        v;
        logic        fl;
        logic        mis;
        int          tc;
        int          sc;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    event sample_now;

    task automatic chk(input string nm, input string what,
                       input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, what, act, req);
        end
    endtask

    // Monitor: compare after every rising edge and after any async event.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sample_now);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "pc_out",       pc_out,       e.pc);
                chk(e.nm, "ifid_pc",      ifid_pc,      e.ifpc);
                chk(e.nm, "ifid_instr",   {32'h0, ifid_instr}, {32'h0, e.ins});
                chk(e.nm, "ifid_valid",   {63'h0, ifid_valid}, {63'h0, e.v});
                chk(e.nm, "flush",        {63'h0, flush},      {63'h0, e.fl});
                chk(e.nm, "misalign_err", {63'h0, misalign_err}, {63'h0, e.mis});
`ifdef BRANCH_STATS_EN
                if (e.tc >= 0) chk(e.nm, "taken_count", {32'h0, taken_count}, 64'(e.tc));
                if (e.sc >= 0) chk(e.nm, "stall_count", {32'h0, stall_count}, 64'(e.sc));
`endif
            end
        end
    end

    function automatic exp_t mk(input logic [63:0] pc, input logic [63:0] ifpc,
                                input logic [31:0] ins, input logic v, input logic fl,
                                input logic mis, input int tc, input int sc,
                                input string nm);
        exp_t e;
        e.pc = pc; e.ifpc = ifpc; e.ins = ins; e.v = v; e.fl = fl;
        e.mis = mis; e.tc = tc; e.sc = sc; e.nm = nm;
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the state
    // expected right after the following rising edge.
    task automatic step(input logic rs, input logic st, input logic bv, input logic bs,
                        input logic [63:0] tgt, input logic [31:0] ins,
                        input exp_t e);
        @(negedge clk);
        reset         = rs;
        stall         = st;
        branch_valid  = bv;
        branch_sel    = bs;
        branch_target = tgt;
        instr_in      = ins;
        sb.push_back(e);
    endtask

    initial begin
        // reset held: reset values visible
        step(1, 0, 0, 0, 64'h0, I0, mk(64'h0, 64'h0, NOP, 0, 0, 0, 0, 0, "rst_hold"));
        // sequential fetch
        step(0, 0, 0, 0, 64'h0, I0, mk(64'h4, 64'h0, I0, 1, 0, 0, -1, -1, "seq0"));
        step(0, 0, 0, 0, 64'h0, I1, mk(64'h8, 64'h4, I1, 1, 0, 0, -1, -1, "seq4"));
        // not-taken branch costs nothing
        step(0, 0, 1, 0, 64'h500, I2, mk(64'hC, 64'h8, I2, 1, 0, 0, 0, 0, "not_taken"));
        step(0, 0, 0, 0, 64'h0, I0, mk(64'h10, 64'hC, I0, 1, 0, 0, -1, -1, "seqC"));
        // taken branch at pc 0x10 -> 0x40, one bubble
        step(0, 0, 1, 1, 64'h40, I0, mk(64'h40, 64'h10, NOP, 0, 1, 0, 1, 0, "taken40"));
        // branch presented while in FLUSH is ignored
        step(0, 0, 1, 1, 64'h80, I1, mk(64'h44, 64'h40, I1, 1, 0, 0, 1, 0, "flush_ign"));
        step(0, 0, 0, 0, 64'h0, I0, mk(64'h48, 64'h44, I0, 1, 0, 0, -1, -1, "after_ign"));
        // stall with a taken branch for two edges, then redirect
        step(0, 1, 1, 1, 64'h200, I2, mk(64'h48, 64'h44, I0, 1, 0, 0, 1, 1, "stall1"));
        step(0, 1, 1, 1, 64'h200, I2, mk(64'h48, 64'h44, I0, 1, 0, 0, 1, 2, "stall2"));
        step(0, 0, 1, 1, 64'h200, I2, mk(64'h200, 64'h48, NOP, 0, 1, 0, 2, 2, "redir200"));
        step(0, 0, 0, 0, 64'h0, I1, mk(64'h204, 64'h200, I1, 1, 0, 0, -1, -1, "seq200"));
        // misaligned target: aligned PC, sticky error
        step(0, 0, 1, 1, 64'h102, I0, mk(64'h100, 64'h204, NOP, 0, 1, 1, 3, 2, "mis102"));
        step(0, 0, 0, 0, 64'h0, I0, mk(64'h104, 64'h100, I0, 1, 0, 1, -1, -1, "mis_sticky1"));
        step(0, 0, 0, 0, 64'h0, I2, mk(64'h108, 64'h104, I2, 1, 0, 1, -1, -1, "mis_sticky2"));
        // PC wrap at top of address space
        step(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, I0,
             mk(64'hFFFF_FFFF_FFFF_FFFC, 64'h108, NOP, 0, 1, 1, 4, 2, "to_top"));
        step(0, 0, 0, 0, 64'h0, I1, mk(64'h0, 64'hFFFF_FFFF_FFFF_FFFC, I1, 1, 0, 1, -1, -1, "wrap"));
        step(0, 0, 0, 0, 64'h0, I0, mk(64'h4, 64'h0, I0, 1, 0, 1, -1, -1, "after_wrap"));
        // enter FLUSH at 0x300, then asynchronous reset mid-cycle
        step(0, 0, 1, 1, 64'h300, I0, mk(64'h300, 64'h4, NOP, 0, 1, 1, 5, 2, "taken300"));
        @(negedge clk);
        branch_valid = 1'b0;
        branch_sel   = 1'b0;
        #2;
        reset = 1'b1;
        sb.push_back(mk(64'h0, 64'h0, NOP, 0, 0, 0, 0, 0, "async_rst"));
        -> sample_now;
        #1;
        step(1, 0, 0, 0, 64'h0, I0, mk(64'h0, 64'h0, NOP, 0, 0, 0, 0, 0, "rst_hold2"));
        step(0, 0, 0, 0, 64'h0, I2, mk(64'h4, 64'h0, I2, 1, 0, 0, 0, 0, "restart"));

        // drain: every queued expectation must have been consumed
        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish before 50000ns");
        $fatal(1, "timeout");
    end

endmodule
